wb_ram_bist_master: RTL and testbench

- Wishbone initiator that drives the five-RAM Wishbone responder (RAM0..RAM4) from the FPGA side.
- On a start pulse it runs a self-test on one selected RAM:
  - writes an address-derived pattern across a programmable number of words;
  - reads every word back and compares it under the RAM's data width;
  - reports pass/fail, error count, first failing address and data, and a bus timeout flag.
- Used for on-silicon RAM bring-up and for regression tests of the RAM responder.

---
 rtl/wb_ram_bist_master.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wb_ram_bist_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_bist_master.sv
// Wishbone initiator that writes an address-derived pattern into one of five
// RAMs, reads it back under that RAM's width mask and reports the result.
module wb_ram_bist_master #(
    parameter int unsigned ADDRWIDTH = 11,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic                 start_i,
    input  logic [2:0]           ram_sel_i,
    input  logic [11:0]          depth_i,
    input  logic [31:0]          seed_i,
    output logic [ADDRWIDTH-1:0] WBs_ADR_o,
    output logic                 WBs_RAM0_CYC_o,
    output logic                 WBs_RAM1_CYC_o,
    output logic                 WBs_RAM2_CYC_o,
    output logic                 WBs_RAM3_CYC_o,
    output logic                 WBs_RAM4_CYC_o,
    output logic [3:0]           WBs_BYTE_STB_o,
    output logic                 WBs_WE_o,
    output logic                 WBs_STB_o,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    input  logic [DATAWIDTH-1:0] WBs_RAM0_DAT_i,
    input  logic [DATAWIDTH-1:0] WBs_RAM1_DAT_i,
    input  logic [DATAWIDTH-1:0] WBs_RAM2_DAT_i,
    input  logic [DATAWIDTH-1:0] WBs_RAM3_DAT_i,
    input  logic [DATAWIDTH-1:0] WBs_RAM4_DAT_i,
    input  logic                 WBs_ACK_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [11:0]          err_cnt_o,
    output logic [ADDRWIDTH-1:0] first_err_adr_o,
    output logic [DATAWIDTH-1:0] first_err_dat_o,
    output logic                 timeout_o
);

    localparam int unsigned CW   = 12;
    localparam int unsigned SW   = 3;
    localparam int unsigned NRAM = 5;
    localparam int unsigned WW   = 4;

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    function automatic logic [CW-1:0] ram_size(input logic [SW-1:0] s);
        case (s)
            3'd0:    return 12'd512;
            3'd1:    return 12'd1024;
            3'd2:    return 12'd1024;
            3'd3:    return 12'd512;
            3'd4:    return 12'd2048;
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [DATAWIDTH-1:0] ram_mask(input logic [SW-1:0] s);
        case (s)
            3'd0, 3'd1: return DATAWIDTH'(32'h0000_FFFF);
            3'd2, 3'd4: return DATAWIDTH'(32'h0000_00FF);
            default:    return DATAWIDTH'(32'hFFFF_FFFF);
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   adr_q, adr_d;
    logic [NRAM-1:0]        cyc_q, cyc_d;
    logic                   stb_q, stb_d, we_q, we_d;
    logic [3:0]             bstb_q, bstb_d;
    logic [DATAWIDTH-1:0]   dat_q, dat_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [31:0]            seed_q, seed_d;
    logic [CW-1:0]          last_q, last_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [CW-1:0]          err_q, err_d;
    logic [ADDRWIDTH-1:0]   fadr_q, fadr_d;
    logic [DATAWIDTH-1:0]   fdat_q, fdat_d;

    logic [DATAWIDTH-1:0]   rd_data_c, mask_c, rd_masked_c, exp_masked_c;
    logic [CW-1:0]          size_c, eff_c;
    logic                   last_hit_c;

    // Read-data select and compare against the expected pattern
    always_comb begin
        case (sel_q)
            3'd0:    rd_data_c = WBs_RAM0_DAT_i;
            3'd1:    rd_data_c = WBs_RAM1_DAT_i;
            3'd2:    rd_data_c = WBs_RAM2_DAT_i;
            3'd3:    rd_data_c = WBs_RAM3_DAT_i;
            3'd4:    rd_data_c = WBs_RAM4_DAT_i;
            default: rd_data_c = '0;
        endcase
        mask_c       = ram_mask(sel_q);
        rd_masked_c  = rd_data_c & mask_c;
        exp_masked_c = (DATAWIDTH'(seed_q) + DATAWIDTH'(adr_q)) & mask_c;
        last_hit_c   = (CW'(adr_q) == last_q);
        size_c       = ram_size(ram_sel_i);
        eff_c        = (depth_i < size_c) ? depth_i : size_c;
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        bstb_d  = bstb_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        seed_d  = seed_q;
        last_d  = last_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        fadr_d  = fadr_q;
        fdat_d  = fdat_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (start_i) begin
                    sel_d  = ram_sel_i;
                    seed_d = seed_i;
                    err_d  = '0;
                    tmo_d  = 1'b0;
                    fadr_d = '0;
                    fdat_d = '0;
                    pass_d = 1'b0;
                    last_d = eff_c - CW'(1);
                    if (ram_sel_i > 3'd4) begin
                        tmo_d   = 1'b1;
                        state_d = FIN;
                    end else if (eff_c == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = WR;
                        adr_d   = '0;
                        cyc_d   = NRAM'(1) << ram_sel_i;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        bstb_d  = 4'hF;
                        dat_d   = DATAWIDTH'(seed_i);
                    end
                end
            end
            WR, RD: begin
                if (WBs_ACK_i) begin
                    wait_d = '0;
                    if (state_q == RD && rd_masked_c != exp_masked_c) begin
                        err_d = err_q + CW'(1);
                        if (err_q == '0) begin
                            fadr_d = adr_q;
                            fdat_d = rd_masked_c;
                        end
                    end
                    if (last_hit_c) begin
                        adr_d = '0;
                        dat_d = '0;
                        we_d  = 1'b0;
                        if (state_q == WR) begin
                            state_d = RD;
                        end else begin
                            state_d = FIN;
                            cyc_d   = '0;
                            stb_d   = 1'b0;
                            bstb_d  = '0;
                        end
                    end else begin
                        adr_d = adr_q + ADDRWIDTH'(1);
                        dat_d = (state_q == WR) ?
                                DATAWIDTH'(seed_q) + DATAWIDTH'(adr_q + ADDRWIDTH'(1)) : '0;
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    // Responder never answered: abandon the bus
                    tmo_d   = 1'b1;
                    state_d = FIN;
                    wait_d  = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    bstb_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !tmo_q;
                wait_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cyc_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            bstb_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            seed_q  <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= '0;
            fadr_q  <= '0;
            fdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            bstb_q  <= bstb_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            seed_q  <= seed_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            fadr_q  <= fadr_d;
            fdat_q  <= fdat_d;
        end
    end

    assign WBs_ADR_o       = adr_q;
    assign WBs_RAM0_CYC_o  = cyc_q[0];
    assign WBs_RAM1_CYC_o  = cyc_q[1];
    assign WBs_RAM2_CYC_o  = cyc_q[2];
    assign WBs_RAM3_CYC_o  = cyc_q[3];
    assign WBs_RAM4_CYC_o  = cyc_q[4];
    assign WBs_BYTE_STB_o  = bstb_q;
    assign WBs_WE_o        = we_q;
    assign WBs_STB_o       = stb_q;
    assign WBs_DAT_o       = dat_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_adr_o = fadr_q;
    assign first_err_dat_o = fdat_q;
    assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Bench for wb_ram_bist_master: five-RAM responder model plus a result
// scoreboard popped on each done pulse.
module tb_wb_ram_bist_master;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [11:0] err;
        logic [10:0] fadr;
        logic [31:0] fdat;
        int          lat;
        int          writes;
        int          cyc_cc;
        int          base_cyc;
        int          base_wr;
        int          base_cc;
        int          base_viol;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    ram_sel;
    logic [11:0]   depth;
    logic [31:0]   seed;
    logic [AW-1:0] adr;
    logic [4:0]    cyc;
    logic [3:0]    byte_stb;
    logic          we, stb;
    logic [DW-1:0] dat;
    logic [DW-1:0] rdat [5];
    logic          ack;
    logic          busy, done, pass, tmo;
    logic [11:0]   err_cnt;
    logic [AW-1:0] fadr;
    logic [DW-1:0] fdat;

    logic          ack_en;
    logic          corrupt;
    logic [31:0]   mem [5][2048];

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc_no = 0;
    int            wr_cnt = 0;
    int            cyc_cc = 0;
    int            viol = 0;
    logic [AW-1:0] last_wr = '0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    wb_ram_bist_master dut (
        .WBs_CLK_i       (clk),
        .WBs_RST_n_i     (rst_n),
        .start_i         (start),
        .ram_sel_i       (ram_sel),
        .depth_i         (depth),
        .seed_i          (seed),
        .WBs_ADR_o       (adr),
        .WBs_RAM0_CYC_o  (cyc[0]),
        .WBs_RAM1_CYC_o  (cyc[1]),
        .WBs_RAM2_CYC_o  (cyc[2]),
        .WBs_RAM3_CYC_o  (cyc[3]),
        .WBs_RAM4_CYC_o  (cyc[4]),
        .WBs_BYTE_STB_o  (byte_stb),
        .WBs_WE_o        (we),
        .WBs_STB_o       (stb),
        .WBs_DAT_o       (dat),
        .WBs_RAM0_DAT_i  (rdat[0]),
        .WBs_RAM1_DAT_i  (rdat[1]),
        .WBs_RAM2_DAT_i  (rdat[2]),
        .WBs_RAM3_DAT_i  (rdat[3]),
        .WBs_RAM4_DAT_i  (rdat[4]),
        .WBs_ACK_i       (ack),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_adr_o (fadr),
        .first_err_dat_o (fdat),
        .timeout_o       (tmo)
    );

    function automatic logic [31:0] wmask(input int i);
        case (i)
            0, 1:    return 32'h0000_FFFF;
            2, 4:    return 32'h0000_00FF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Responder: ACK one cycle after STB, never back-to-back; narrow RAMs
    // return ones in the unused upper bits so the compare mask matters.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= ack_en && (|cyc) && stb && !ack;
    end

    always @(posedge clk) begin
        if (ack && stb && we)
            for (int i = 0; i < 5; i++)
                if (cyc[i]) mem[i][adr] <= dat & wmask(i);
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rdat[i] = (mem[i][adr] & wmask(i)) | ~wmask(i);
            if (corrupt && i == 0 && adr == 11'd5) rdat[i][3] = ~rdat[i][3];
        end
    end

    always @(posedge clk) cyc_no <= cyc_no + 1;

    always @(negedge clk) begin
        if (|cyc) cyc_cc <= cyc_cc + 1;
        if ((|cyc) && stb && we && ack) begin
            wr_cnt  <= wr_cnt + 1;
            last_wr <= adr;
        end
        if ((stb && byte_stb != 4'hF) || (!stb && byte_stb != 4'h0) ||
            ($countones(cyc) > 1) || (stb && cyc == 5'b0))
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic t, input logic [11:0] er,
                                input logic [10:0] fa, input logic [31:0] fd,
                                input int lat, input int wr, input int cc);
        exp_t e;
        e.pass = p; e.tmo = t; e.err = er; e.fadr = fa; e.fdat = fd;
        e.lat = lat; e.writes = wr; e.cyc_cc = cc;
        e.base_cyc = 0; e.base_wr = 0; e.base_cc = 0; e.base_viol = 0;
        return e;
    endfunction

    task automatic run(input logic [2:0] s, input logic [11:0] d, input logic [31:0] sd,
                       input logic ae, input logic cr, input exp_t e);
        exp_t g;
        bit   seen;
        @(negedge clk);
        ack_en = ae; corrupt = cr;
        ram_sel = s; depth = d; seed = sd; start = 1'b1;
        e.base_cyc = cyc_no; e.base_wr = wr_cnt; e.base_cc = cyc_cc; e.base_viol = viol;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 9000 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_wait", 64'(0), 64'(1));
            sb.delete();
        end else begin
            g = sb.pop_front();
            check("pass",      64'(pass),                 64'(g.pass));
            check("timeout",   64'(tmo),                  64'(g.tmo));
            check("err_cnt",   64'(err_cnt),              64'(g.err));
            check("first_adr", 64'(fadr),                 64'(g.fadr));
            check("first_dat", 64'(fdat),                 64'(g.fdat));
            check("latency",   64'(cyc_no - g.base_cyc),  64'(g.lat));
            check("writes",    64'(wr_cnt - g.base_wr),   64'(g.writes));
            check("cyc_cycles",64'(cyc_cc - g.base_cc),   64'(g.cyc_cc));
            check("bus_rules", 64'(viol - g.base_viol),   64'(0));
            if (g.writes > 0) check("last_wr", 64'(last_wr), 64'(g.writes - 1));
            @(negedge clk);
            #1;
            check("done_pulse", 64'(done), 64'(0));
            check("busy_end",   64'(busy), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] fd0;
        bit          found;
        rst_n = 1'b0; start = 1'b0; ram_sel = '0; depth = '0; seed = '0;
        ack_en = 1'b1; corrupt = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cyc",  64'(cyc),      64'(0));
        check("rst_stb",  64'(stb),      64'(0));
        check("rst_busy", 64'(busy),     64'(0));
        check("rst_done", 64'(done),     64'(0));
        check("rst_pass", 64'(pass),     64'(0));
        check("rst_tmo",  64'(tmo),      64'(0));
        rst_n = 1'b1;

        run(3'd3, 12'd512,  32'hA5A5_0000, 1'b1, 1'b0, mk(1'b1, 1'b0, 12'd0, 11'd0, 32'd0, 2050, 512, 2048));
        run(3'd2, 12'd4095, 32'h0BAD_F00D, 1'b1, 1'b0, mk(1'b1, 1'b0, 12'd0, 11'd0, 32'd0, 4098, 1024, 4096));
        fd0 = ((32'h1234_5678 + 32'd5) ^ 32'h8) & 32'h0000_FFFF;
        run(3'd0, 12'd16,   32'h1234_5678, 1'b1, 1'b1, mk(1'b0, 1'b0, 12'd1, 11'd5, fd0, 66, 16, 64));
        run(3'd1, 12'd10,   32'h0000_0001, 1'b0, 1'b0, mk(1'b0, 1'b1, 12'd0, 11'd0, 32'd0, 17, 0, 15));
        run(3'd3, 12'd0,    32'h0000_0002, 1'b1, 1'b0, mk(1'b1, 1'b0, 12'd0, 11'd0, 32'd0, 2, 0, 0));
        run(3'd6, 12'd10,   32'h0000_0003, 1'b1, 1'b0, mk(1'b0, 1'b1, 12'd0, 11'd0, 32'd0, 2, 0, 0));

        // Reset in the middle of the read pass on RAM4
        @(negedge clk);
        ack_en = 1'b1; corrupt = 1'b0;
        ram_sel = 3'd4; depth = 12'd64; seed = 32'hCAFE_0000; start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (stb && !we) found = 1'b1;
        end
        check("rd_reached", 64'(found), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc",  64'(cyc),     64'(0));
        check("mid_rst_stb",  64'(stb),     64'(0));
        check("mid_rst_busy", 64'(busy),    64'(0));
        check("mid_rst_adr",  64'(adr),     64'(0));
        check("mid_rst_err",  64'(err_cnt), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(3'd4, 12'd2048, $urandom, 1'b1, 1'b0, mk(1'b1, 1'b0, 12'd0, 11'd0, 32'd0, 8194, 2048, 8192));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
